// File: rtl/bp_fe_cache_req_arbiter.sv
// Shares the front-end cache request port between the I$ demand-miss path (req 0)
// and the instruction prefetcher (req 1); one transaction in flight, demand first.
module bp_fe_cache_req_arbiter #(
    parameter int req_width_p      = 64,
    parameter int metadata_width_p = 8,
    parameter int starve_limit_p   = 15
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,

    input  logic [req_width_p-1:0]      req_i [2],
    input  logic [1:0]                  req_v_i,
    output logic [1:0]                  req_yumi_o,
    input  logic [metadata_width_p-1:0] req_metadata_i [2],
    input  logic [1:0]                  req_metadata_v_i,
    output logic [1:0]                  req_critical_o,
    output logic [1:0]                  req_last_o,

    output logic [req_width_p-1:0]      cache_req_o,
    output logic                        cache_req_v_o,
    input  logic                        cache_req_yumi_i,
    output logic [metadata_width_p-1:0] cache_req_metadata_o,
    output logic                        cache_req_metadata_v_o,
    input  logic                        cache_req_critical_i,
    input  logic                        cache_req_last_i,
    input  logic                        cache_req_credits_full_i
);

    localparam int cnt_width_lp = $clog2(starve_limit_p + 1);

    typedef enum logic [1:0] {IDLE, SEND, META, BUSY} state_e;

    state_e                  state_r, state_n;
    logic                    owner_r, owner_n;
    logic [cnt_width_lp-1:0] starve_cnt_r, starve_cnt_n;
    logic                    starved;

    function automatic logic [cnt_width_lp-1:0] sat_inc(input logic [cnt_width_lp-1:0] v);
        return (v == cnt_width_lp'(starve_limit_p)) ? v : v + 1'b1;
    endfunction

    assign starved = (starve_cnt_r == cnt_width_lp'(starve_limit_p));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= IDLE;
            owner_r      <= 1'b0;
            starve_cnt_r <= '0;
        end else begin
            state_r      <= state_n;
            owner_r      <= owner_n;
            starve_cnt_r <= starve_cnt_n;
        end
    end

    always_comb begin
        state_n                = state_r;
        owner_n                = owner_r;
        starve_cnt_n           = starve_cnt_r;
        req_yumi_o             = '0;
        req_critical_o         = '0;
        req_last_o             = '0;
        cache_req_o            = '0;
        cache_req_v_o          = 1'b0;
        cache_req_metadata_o   = '0;
        cache_req_metadata_v_o = 1'b0;

        unique case (state_r)
            IDLE: begin
                if (!req_v_i[1])
                    starve_cnt_n = '0;
                if (!cache_req_credits_full_i && (|req_v_i)) begin
                    state_n = SEND;
                    if (req_v_i[0] && !(starved && req_v_i[1])) begin
                        owner_n = 1'b0;
                        if (req_v_i[1])
                            starve_cnt_n = sat_inc(starve_cnt_r);
                    end else begin
                        owner_n      = 1'b1;
                        starve_cnt_n = '0;
                    end
                end
            end
            SEND: begin
                cache_req_o   = req_i[owner_r];
                cache_req_v_o = req_v_i[owner_r];
                if (req_v_i[owner_r] && cache_req_yumi_i) begin
                    req_yumi_o[owner_r] = 1'b1;
                    state_n             = META;
                end else if (owner_r && req_v_i[0]) begin
                    // Demand steals an unaccepted prefetch; no ack, no starve event.
                    owner_n = 1'b0;
                end else if (!req_v_i[owner_r]) begin
                    state_n = IDLE;
                end
            end
            META: begin
                cache_req_metadata_o    = req_metadata_i[owner_r];
                cache_req_metadata_v_o  = req_metadata_v_i[owner_r];
                req_critical_o[owner_r] = cache_req_critical_i;
                req_last_o[owner_r]     = cache_req_last_i;
                if (cache_req_last_i)
                    state_n = IDLE;
                else if (req_metadata_v_i[owner_r])
                    state_n = BUSY;
            end
            BUSY: begin
                req_critical_o[owner_r] = cache_req_critical_i;
                req_last_o[owner_r]     = cache_req_last_i;
                if (cache_req_last_i)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bp_fe_cache_req_arbiter.sv
// Directed bench for bp_fe_cache_req_arbiter: expected grants are queued when
// requests are raised and compared when the arbiter acknowledges a requester.
module tb_bp_fe_cache_req_arbiter;

    localparam int RW  = 64;
    localparam int MW  = 8;
    localparam int LIM = 15;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [RW-1:0] req [2];
    logic [1:0]    req_v = '0;
    logic [1:0]    req_yumi;
    logic [MW-1:0] meta [2];
    logic [1:0]    meta_v = 2'b11;
    logic [1:0]    crit_o, last_o;
    logic [RW-1:0] creq;
    logic          creq_v;
    logic          yumi = 1'b0;
    logic [MW-1:0] cmeta;
    logic          cmeta_v;
    logic          crit = 1'b0;
    logic          last = 1'b0;
    logic          cfull = 1'b0;

    int tests = 0;
    int fails = 0;
    int dual_yumi = 0;
    int n;

    typedef struct {
        logic          owner;
        logic [RW-1:0] data;
    } exp_t;
    exp_t sb [$];

    always #5 clk = ~clk;

    bp_fe_cache_req_arbiter #(
        .req_width_p(RW), .metadata_width_p(MW), .starve_limit_p(LIM)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .req_i(req),
        .req_v_i(req_v),
        .req_yumi_o(req_yumi),
        .req_metadata_i(meta),
        .req_metadata_v_i(meta_v),
        .req_critical_o(crit_o),
        .req_last_o(last_o),
        .cache_req_o(creq),
        .cache_req_v_o(creq_v),
        .cache_req_yumi_i(yumi),
        .cache_req_metadata_o(cmeta),
        .cache_req_metadata_v_o(cmeta_v),
        .cache_req_critical_i(crit),
        .cache_req_last_i(last),
        .cache_req_credits_full_i(cfull)
    );

    always @(negedge clk)
        if (req_yumi == 2'b11) dual_yumi++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [1:0] onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

    task automatic expect_grant(input logic owner);
        exp_t e;
        e.owner = owner;
        e.data  = req[owner];
        sb.push_back(e);
    endtask

    task automatic wait_send(input int max, output int cycles);
        cycles = 0;
        while (!creq_v && cycles < max) begin
            step();
            cycles++;
        end
        check("send_timeout", creq_v, 1'b1);
    endtask

    task automatic accept();
        exp_t e;
        yumi = 1'b1;
        settle();
        check("sb_nonempty", 64'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("yumi_owner", req_yumi, onehot(e.owner));
            check("req_data", creq, e.data);
        end
        step();
        yumi = 1'b0;
    endtask

    task automatic finish_txn(input logic owner);
        settle();
        check("meta_data", cmeta, meta[owner]);
        check("meta_v", cmeta_v, 1'b1);
        step();
        crit = 1'b1;
        settle();
        check("crit_route", crit_o, onehot(owner));
        check("last_quiet", last_o, 2'b00);
        step();
        crit = 1'b0;
        last = 1'b1;
        settle();
        check("last_route", last_o, onehot(owner));
        check("crit_quiet", crit_o, 2'b00);
        step();
        last = 1'b0;
        settle();
        check("idle_v", creq_v, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        req[0]  = 64'hD0D0_1111_2222_0000;
        req[1]  = 64'hF1F1_3333_4444_0001;
        meta[0] = 8'hA0;
        meta[1] = 8'hB1;

        // Reset state
        req_v = 2'b11;
        step();
        settle();
        check("rst_v", creq_v, 1'b0);
        check("rst_yumi", req_yumi, 2'b00);
        check("rst_meta_v", cmeta_v, 1'b0);
        check("rst_req", creq, 64'h0);
        req_v = 2'b00;
        step();
        reset_n = 1'b1;
        step();

        // Single demand request
        req_v = 2'b01;
        expect_grant(1'b0);
        settle();
        check("arb_latency_v", creq_v, 1'b0);
        wait_send(5, n);
        check("arb_latency", 64'(n), 1);
        crit = 1'b1;
        settle();
        check("send_crit_drop", crit_o, 2'b00);
        crit = 1'b0;
        step();
        check("send_hold_v", creq_v, 1'b1);
        check("send_hold_yumi", req_yumi, 2'b00);
        accept();
        req_v = 2'b00;
        finish_txn(1'b0);

        // Both valid: fifteen demand grants then one prefetch grant, twice
        req_v = 2'b11;
        for (int i = 0; i < 32; i++) begin
            expect_grant((i % 16) == 15);
            wait_send(5, n);
            accept();
            finish_txn((i % 16) == 15);
        end
        req_v = 2'b00;
        step();

        // Demand preempts an unaccepted prefetch
        req_v = 2'b10;
        wait_send(5, n);
        check("pf_send_data", creq, req[1]);
        req_v = 2'b11;
        expect_grant(1'b0);
        step();
        check("preempt_data", creq, req[0]);
        check("preempt_no_ack", req_yumi, 2'b00);
        accept();
        req_v = 2'b10;
        finish_txn(1'b0);
        expect_grant(1'b1);
        wait_send(5, n);
        accept();
        req_v = 2'b00;
        finish_txn(1'b1);

        // No grant while credits are exhausted
        cfull = 1'b1;
        req_v = 2'b11;
        expect_grant(1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("credits_full_v", creq_v, 1'b0);
        end
        cfull = 1'b0;
        wait_send(5, n);
        check("credits_release", 64'(n), 1);
        accept();
        req_v = 2'b00;
        finish_txn(1'b0);

        // Prefetch owns the response stream; demand metadata is ignored
        req_v = 2'b10;
        meta_v = 2'b01;
        expect_grant(1'b1);
        wait_send(5, n);
        accept();
        req_v = 2'b00;
        settle();
        check("nonowner_meta_v", cmeta_v, 1'b0);
        step();
        check("still_meta_data", cmeta, meta[1]);
        check("still_meta_v", cmeta_v, 1'b0);
        meta_v = 2'b10;
        finish_txn(1'b1);
        meta_v = 2'b11;

        // Reset during BUSY
        req_v = 2'b01;
        expect_grant(1'b0);
        wait_send(5, n);
        accept();
        req_v = 2'b00;
        step();
        crit = 1'b1;
        settle();
        check("busy_crit", crit_o, 2'b01);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_crit", crit_o, 2'b00);
        check("async_rst_v", creq_v, 1'b0);
        check("async_rst_meta_v", cmeta_v, 1'b0);
        crit = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        req_v = 2'b01;
        expect_grant(1'b0);
        wait_send(5, n);
        check("post_rst_latency", 64'(n), 1);
        accept();
        req_v = 2'b00;
        finish_txn(1'b0);

        check("no_dual_yumi", 64'(dual_yumi), 0);
        check("sb_drained", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
